// File: rtl/cpi_dispatch_pkg.sv
// Shared types and constants for the CPI dispatcher: FSM states, fault causes,
// opcode field position and the CPU response-flag ordering {wait, ready, drop}.
package cpi_dispatch_pkg;

    localparam int CPI_OPCODE_HI = 31;
    localparam int CPI_OPCODE_LO = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_FAULT
    } state_e;

    typedef enum logic {
        CAUSE_ILLEGAL,
        CAUSE_TIMEOUT
    } cause_e;

    // Packed so that {cpi_wait, cpi_ready, cpi_drop} can be assigned in one go
    typedef struct packed {
        logic waitFlag;
        logic ready;
        logic drop;
    } cpi_flags_t;

    typedef struct packed {
        logic [31:0] data;
        logic        waitFlag;
        logic        drop;
    } slot_resp_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cpi_dispatch_match.sv
// Opcode-to-slot decoder: per-slot mask/value compare followed by a
// lowest-index-wins priority encoder.
module cpi_match
    import cpi_dispatch_pkg::*;
#(
    parameter int                    NUM_CP     = 3,
    parameter logic [8*NUM_CP-1:0]   CP_OPCODES = {8'he0, 8'hfe, 8'hff},
    parameter logic [8*NUM_CP-1:0]   CP_MASKS   = {8'hf0, 8'hff, 8'hff},
    parameter int                    SW         = idxWidth(NUM_CP)
) (
    input  logic [7:0]    opcode_i,
    output logic          hit_o,
    output logic [SW-1:0] slot_o
);

    // Walking from the top slot down lets the lowest matching index overwrite
    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        for (int i = NUM_CP - 1; i >= 0; i--) begin
            if ((opcode_i & CP_MASKS[8*i +: 8]) == CP_OPCODES[8*i +: 8]) begin
                hit_o  = 1'b1;
                slot_o = SW'(i);
            end
        end
    end

endmodule

// File: rtl/cpi_dispatch.sv
// CPI dispatcher: routes one CPU coprocessor instruction to exactly one slot and
// returns its response, or a fault response on no match or slot timeout.
module cpi_dispatch
    import cpi_dispatch_pkg::*;
#(
    parameter int                  NUM_CP     = 3,
    parameter logic [8*NUM_CP-1:0] CP_OPCODES = {8'he0, 8'hfe, 8'hff},
    parameter logic [8*NUM_CP-1:0] CP_MASKS   = {8'hf0, 8'hff, 8'hff},
    parameter int                  TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpi_valid,
    input  logic [31:0]           cpi_inst,
    input  logic [31:0]           cpi_r1,
    input  logic [31:0]           cpi_r2,
    output logic                  cpi_ready,
    output logic                  cpi_wait,
    output logic                  cpi_drop,
    output logic [31:0]           cpi_data,

    output logic [NUM_CP-1:0]     cp_valid,
    output logic [31:0]           cp_inst,
    output logic [31:0]           cp_r1,
    output logic [31:0]           cp_r2,
    input  logic [NUM_CP-1:0]     cp_ready,
    input  logic [NUM_CP-1:0]     cp_wait,
    input  logic [NUM_CP-1:0]     cp_drop,
    input  logic [32*NUM_CP-1:0]  cp_data,

    output logic                  fault_illegal,
    output logic                  fault_timeout,
    output logic [7:0]            illegal_count
);

    localparam int SW = idxWidth(NUM_CP);
    localparam int TW = idxWidth(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_e       state_q,  state_d;
    cause_e       cause_q,  cause_d;
    logic [SW-1:0] slot_q,  slot_d;
    logic [TW-1:0] timer_q, timer_d;
    slot_resp_t   resp_q,   resp_d;
    logic [7:0]   count_q,  count_d;
    logic [31:0]  cpInst_q, cpInst_d;
    logic [31:0]  cpR1_q,   cpR1_d;
    logic [31:0]  cpR2_q,   cpR2_d;

    logic          matchHit;
    logic [SW-1:0] matchSlot;
    int            slotIdx;
    cpi_flags_t    flags;

    cpi_match #(
        .NUM_CP     (NUM_CP),
        .CP_OPCODES (CP_OPCODES),
        .CP_MASKS   (CP_MASKS),
        .SW         (SW)
    ) u_match (
        .opcode_i (cpi_inst[CPI_OPCODE_HI:CPI_OPCODE_LO]),
        .hit_o    (matchHit),
        .slot_o   (matchSlot)
    );

    assign slotIdx = int'(slot_q);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        slot_d   = slot_q;
        timer_d  = timer_q;
        resp_d   = resp_q;
        count_d  = count_q;
        cpInst_d = cpInst_q;
        cpR1_d   = cpR1_q;
        cpR2_d   = cpR2_q;

        case (state_q)
            ST_IDLE: begin
                if (cpi_valid) begin
                    cpInst_d = cpi_inst;
                    cpR1_d   = cpi_r1;
                    cpR2_d   = cpi_r2;
                    if (matchHit) begin
                        slot_d  = matchSlot;
                        timer_d = '0;
                        state_d = ST_BUSY;
                    end else begin
                        cause_d = CAUSE_ILLEGAL;
                        count_d = satInc8(count_q);
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_BUSY: begin
                timer_d = timer_q + TW'(1);
                // A response on the expiry cycle still wins over the timeout
                if (cp_ready[slot_q]) begin
                    resp_d.data     = cp_data[32*slotIdx +: 32];
                    resp_d.waitFlag = cp_wait[slot_q];
                    resp_d.drop     = cp_drop[slot_q];
                    state_d         = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    cause_d = CAUSE_TIMEOUT;
                    count_d = satInc8(count_q);
                    state_d = ST_FAULT;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flags         = '0;
        cpi_data      = '0;
        cp_valid      = '0;
        fault_illegal = 1'b0;
        fault_timeout = 1'b0;

        case (state_q)
            ST_BUSY: begin
                cp_valid[slot_q] = 1'b1;
                flags.waitFlag   = 1'b1;
            end
            ST_RESP: begin
                flags.ready    = 1'b1;
                flags.waitFlag = resp_q.waitFlag;
                flags.drop     = resp_q.drop;
                cpi_data       = resp_q.data;
            end
            ST_FAULT: begin
                flags.ready   = 1'b1;
                fault_illegal = (cause_q == CAUSE_ILLEGAL);
                fault_timeout = (cause_q == CAUSE_TIMEOUT);
            end
            default: ;
        endcase
    end

    assign {cpi_wait, cpi_ready, cpi_drop} = flags;
    assign cp_inst       = cpInst_q;
    assign cp_r1         = cpR1_q;
    assign cp_r2         = cpR2_q;
    assign illegal_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_ILLEGAL;
            slot_q   <= '0;
            timer_q  <= '0;
            resp_q   <= '0;
            count_q  <= '0;
            cpInst_q <= '0;
            cpR1_q   <= '0;
            cpR2_q   <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            slot_q   <= slot_d;
            timer_q  <= timer_d;
            resp_q   <= resp_d;
            count_q  <= count_d;
            cpInst_q <= cpInst_d;
            cpR1_q   <= cpR1_d;
            cpR2_q   <= cpR2_d;
        end
    end

endmodule

// File: tb/tb_cpi_dispatch.sv
// Scoreboard bench for cpi_dispatch: randomized CPU requests and coprocessor
// behaviour, expected responses derived from the opcode/timeout rules.
module tb_cpi_dispatch;

    localparam int NUM_CP  = 3;
    localparam int TIMEOUT = 6;
    localparam logic [8*NUM_CP-1:0] OPS   = {8'he0, 8'hfe, 8'hff};
    localparam logic [8*NUM_CP-1:0] MASKS = {8'hf0, 8'hff, 8'hff};

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cpi_valid = 1'b0;
    logic [31:0]          cpi_inst = '0, cpi_r1 = '0, cpi_r2 = '0;
    logic                 cpi_ready, cpi_wait, cpi_drop;
    logic [31:0]          cpi_data;
    logic [NUM_CP-1:0]    cp_valid;
    logic [31:0]          cp_inst, cp_r1, cp_r2;
    logic [NUM_CP-1:0]    cp_ready = '0, cp_wait = '0, cp_drop = '0;
    logic [32*NUM_CP-1:0] cp_data = '0;
    logic                 fault_illegal, fault_timeout;
    logic [7:0]           illegal_count;

    typedef struct {
        int          respCyc;
        logic [31:0] data;
        logic        waitF;
        logic        dropF;
        logic        fIll;
        logic        fTo;
        logic [7:0]  count;
        logic [31:0] inst;
        logic [31:0] r1;
        logic [31:0] r2;
    } expect_t;

    expect_t           expQ[$];
    logic [NUM_CP-1:0] expBusy[int];
    int                cyc = 0;
    int                vectors = 0;
    int                miscompares = 0;
    int                modelCount = 0;
    bit                monEn = 1'b0;
    logic [NUM_CP-1:0] monExpCv;
    expect_t           monE;

    cpi_dispatch #(
        .NUM_CP(NUM_CP), .CP_OPCODES(OPS), .CP_MASKS(MASKS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpi_valid(cpi_valid), .cpi_inst(cpi_inst), .cpi_r1(cpi_r1), .cpi_r2(cpi_r2),
        .cpi_ready(cpi_ready), .cpi_wait(cpi_wait), .cpi_drop(cpi_drop), .cpi_data(cpi_data),
        .cp_valid(cp_valid), .cp_inst(cp_inst), .cp_r1(cp_r1), .cp_r2(cp_r2),
        .cp_ready(cp_ready), .cp_wait(cp_wait), .cp_drop(cp_drop), .cp_data(cp_data),
        .fault_illegal(fault_illegal), .fault_timeout(fault_timeout),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Coprocessor slots chatter randomly; only the masked (selected) slot is held quiet
    task automatic driveNoise(input logic [NUM_CP-1:0] quiet);
        logic [31:0] r;
        r = $urandom;
        cp_ready = r[NUM_CP-1:0] & ~quiet;
        r = $urandom;
        cp_wait = r[NUM_CP-1:0];
        r = $urandom;
        cp_drop = r[NUM_CP-1:0];
        for (int i = 0; i < NUM_CP; i++) cp_data[32*i +: 32] = $urandom;
    endtask

    // One CPU request; d = cycles after cp_valid rises before the slot answers
    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] r1,
                                 input logic [31:0] r2, input int d,
                                 input logic [31:0] rdata, input logic rw,
                                 input logic rd, input int gap);
        int n, slot, k;
        bit hit;
        logic [7:0] op, ops, msk;
        logic [8*NUM_CP-1:0] opsAll, masksAll;
        logic [NUM_CP-1:0] sel;
        expect_t e;

        repeat (gap) begin
            @(posedge clk); #1;
            cpi_valid = 1'b0;
            driveNoise('0);
        end
        @(posedge clk); #1;
        cpi_valid = 1'b1;
        cpi_inst  = inst;
        cpi_r1    = r1;
        cpi_r2    = r2;
        driveNoise('0);
        n = cyc;

        opsAll = OPS;
        masksAll = MASKS;
        op = inst[31:24];
        hit = 1'b0;
        slot = 0;
        for (int i = 0; i < NUM_CP; i++) begin
            ops = opsAll[8*i +: 8];
            msk = masksAll[8*i +: 8];
            if (!hit && ((op & msk) == ops)) begin
                hit = 1'b1;
                slot = i;
            end
        end

        e = '{respCyc: 0, data: '0, waitF: 1'b0, dropF: 1'b0, fIll: 1'b0, fTo: 1'b0,
              count: '0, inst: inst, r1: r1, r2: r2};
        sel = '0;
        if (!hit) begin
            if (modelCount < 255) modelCount++;
            e.respCyc = n + 1;
            e.fIll = 1'b1;
        end else begin
            sel[slot] = 1'b1;
            if (d >= TIMEOUT) begin
                for (int j = 0; j < TIMEOUT; j++) expBusy[n + 1 + j] = sel;
                if (modelCount < 255) modelCount++;
                e.respCyc = n + 1 + TIMEOUT;
                e.fTo = 1'b1;
            end else begin
                for (int j = 0; j <= d; j++) expBusy[n + 1 + j] = sel;
                e.respCyc = n + 2 + d;
                e.data = rdata;
                e.waitF = rw;
                e.dropF = rd;
            end
        end
        e.count = modelCount[7:0];
        expQ.push_back(e);

        for (int c = n + 1; c <= e.respCyc; c++) begin
            @(posedge clk); #1;
            k = c - n - 1;
            cpi_r2 = $urandom;
            driveNoise(sel);
            if (hit && d < TIMEOUT) begin
                if (k < d) cp_wait[slot] = 1'b1;
                if (k == d) begin
                    cp_ready[slot] = 1'b1;
                    cp_wait[slot] = rw;
                    cp_drop[slot] = rd;
                    cp_data[32*slot +: 32] = rdata;
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on each CPU response, otherwise checks quiet/busy outputs
    always @(negedge clk) begin
        if (monEn) begin
            monExpCv = expBusy.exists(cyc) ? expBusy[cyc] : '0;
            while (expQ.size() > 0 && expQ[0].respCyc < cyc) begin
                checkOutput("response missing", 256'(cyc), 256'(expQ[0].respCyc));
                void'(expQ.pop_front());
            end
            if (cpi_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious ready", 256'(cpi_ready), 256'(0));
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("response cycle", 256'(cyc), 256'(monE.respCyc));
                    checkOutput("response payload",
                        {cpi_data, cpi_wait, cpi_drop, fault_illegal, fault_timeout,
                         illegal_count, cp_inst, cp_r1, cp_r2, cp_valid},
                        {monE.data, monE.waitF, monE.dropF, monE.fIll, monE.fTo,
                         monE.count, monE.inst, monE.r1, monE.r2, {NUM_CP{1'b0}}});
                end
            end else begin
                checkOutput("busy/idle outputs",
                    {cp_valid, cpi_wait, cpi_drop, cpi_data, fault_illegal, fault_timeout},
                    {monExpCv, (monExpCv != '0), 1'b0, 32'h0, 1'b0, 1'b0});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rinst, rnd, rr1, rr2, rdat;
        int sel, d, gap;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset state",
            {cpi_ready, cpi_wait, cpi_drop, cpi_data, cp_valid, cp_inst, cp_r1, cp_r2,
             fault_illegal, fault_timeout, illegal_count}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        monEn = 1'b1;

        // Directed cases
        applyStimulus(32'hfe000000, 32'h11, 32'h22, 1, 32'h1234, 1'b0, 1'b1, 0);
        applyStimulus(32'he5000003, 32'h3, 32'h1, 4, 32'h8, 1'b1, 1'b0, 1);
        applyStimulus(32'h12000000, 32'h5, 32'h6, 0, 32'h0, 1'b0, 1'b0, 0);
        applyStimulus(32'he0000000, 32'h7, 32'h8, TIMEOUT, 32'h0, 1'b0, 1'b0, 0);
        applyStimulus(32'hfe00ffff, 32'h9, 32'ha, TIMEOUT - 1, 32'hcafe, 1'b1, 1'b1, 0);
        applyStimulus(32'hff000001, 32'hb, 32'hc, 0, 32'h5a5a, 1'b0, 1'b0, 2);

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            sel = $urandom_range(0, 9);
            rnd = $urandom;
            if (sel < 2)      rinst = {8'hff, rnd[23:0]};
            else if (sel < 4) rinst = {8'hfe, rnd[23:0]};
            else if (sel < 7) rinst = {4'he, rnd[27:0]};
            else              rinst = rnd;
            rr1 = $urandom;
            rr2 = $urandom;
            rdat = $urandom;
            d = $urandom_range(0, TIMEOUT + 1);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            rnd = $urandom;
            applyStimulus(rinst, rr1, rr2, d, rdat, rnd[0], rnd[1], gap);
        end

        // Back-to-back illegal requests drive the fault counter into saturation
        for (int t = 0; t < 300; t++)
            applyStimulus(32'h12000000 + t, t, ~t, 0, 32'h0, 1'b0, 1'b0, 0);

        @(posedge clk); #1;
        cpi_valid = 1'b0;
        driveNoise('0);
        repeat (3) @(negedge clk);
        checkOutput("queue drained", 256'(expQ.size()), 256'(0));
        checkOutput("count saturated", 256'(illegal_count), 256'(8'hff));

        // Reset in the middle of BUSY, then a late ready from the abandoned slot
        monEn = 1'b0;
        @(posedge clk); #1;
        cpi_valid = 1'b1;
        cpi_inst  = 32'hfe00abcd;
        cpi_r1    = 32'h1111;
        cpi_r2    = 32'h2222;
        cp_ready  = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("busy before reset", {cp_valid, cpi_wait}, {3'b010, 1'b1});
        @(posedge clk); #1;
        rst = 1'b1;
        cpi_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cp_ready = 3'b010;
        cp_data[63:32] = 32'hdeadbeef;
        @(negedge clk);
        checkOutput("reset outputs",
            {cpi_ready, cpi_wait, cpi_drop, cpi_data, cp_valid, cp_inst, cp_r1, cp_r2,
             fault_illegal, fault_timeout, illegal_count}, '0);
        @(posedge clk); #1;
        cp_ready = '0;
        @(negedge clk);
        checkOutput("late ready ignored", {cpi_ready, cp_valid, cpi_data}, '0);

        // Recovery after reset: counter restarts from zero
        modelCount = 0;
        expQ.delete();
        monEn = 1'b1;
        applyStimulus(32'h34000000, 32'h1, 32'h2, 0, 32'h0, 1'b0, 1'b0, 0);
        applyStimulus(32'hff000000, 32'h3, 32'h4, 2, 32'h77, 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        cpi_valid = 1'b0;
        driveNoise('0);
        repeat (3) @(negedge clk);
        checkOutput("final queue drained", 256'(expQ.size()), 256'(0));
        checkOutput("count after reset", 256'(illegal_count), 256'(8'd1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
